// File: rtl/tdp36k_fifo_ctrl_if.sv
// Stream bundle for tdp36k_fifo_ctrl: valid/ready push side and FWFT pop side.
// master = the datapath using the FIFO, slave = the FIFO controller.
interface tdp36k_fifo_ctrl_if;
    logic [35:0] WR_DATA;
    logic        WR_VALID;
    logic        WR_READY;
    logic [35:0] RD_DATA;
    logic        RD_VALID;
    logic        RD_READY;

    modport master (
        output WR_DATA, WR_VALID, RD_READY,
        input  WR_READY, RD_DATA, RD_VALID
    );

    modport slave (
        input  WR_DATA, WR_VALID, RD_READY,
        output WR_READY, RD_DATA, RD_VALID
    );
endinterface

// File: rtl/tdp36k_fifo_ctrl.sv
// FIFO controller for one TDP_RAM36K (36-bit mode): port A writes, port B prefetches into a 2-entry FWFT buffer.
// Define TDP36K_FIFO_PARITY_EN to generate per-byte even parity on write and check it on read (sticky PAR_ERR).
module tdp36k_fifo_ctrl #(
    parameter int ADDR_WIDTH         = 10,
    parameter int ALMOST_FULL_THRESH = 1020
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  FLUSH,
    tdp36k_fifo_ctrl_if.slave     stream,
    output logic [ADDR_WIDTH+1:0] COUNT,
    output logic                  ALMOST_FULL,
    output logic                  PAR_ERR,
    output logic                  RAM_WEN_A,
    output logic [3:0]            RAM_BE_A,
    output logic [14:0]           RAM_ADDR_A,
    output logic [31:0]           RAM_WDATA_A,
    output logic [3:0]            RAM_WPARITY_A,
    output logic                  RAM_REN_B,
    output logic [14:0]           RAM_ADDR_B,
    input  logic [31:0]           RAM_RDATA_B,
    input  logic [3:0]            RAM_RPARITY_B
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   RAM_FULL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   RAM_EMPTY = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH+1:0] AF_THRESH = (ADDR_WIDTH+2)'(ALMOST_FULL_THRESH);

`ifdef TDP36K_FIFO_PARITY_EN
    function automatic logic [3:0] byte_parity(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [35:0]           buf0_q, buf0_d, buf1_q, buf1_d;
    logic [ADDR_WIDTH+1:0] count_q, count_d;
    logic                  af_q, af_d;
    logic                  par_err_q, par_err_d;
    logic                  rdy_en_q;
    logic                  wr_ready_s, push_s, pop_s, issue_s;
    logic [2:0]            occ_s;
    logic [35:0]           rd_word_s;
    logic [3:0]            wparity_s;

    // Handshakes, prefetch issue and next-state of pointers, counters and output buffer.
    always_comb begin
        wr_ready_s = rdy_en_q && !FLUSH && (ram_cnt_q < RAM_FULL);
        push_s     = stream.WR_VALID && wr_ready_s;
        pop_s      = (buf_cnt_q != 2'd0) && stream.RD_READY;
        occ_s      = 3'(buf_cnt_q) + 3'(inflight_q);
        // Keep buffered + in-flight words within the 2 buffer slots after this cycle's pop.
        issue_s    = (ram_cnt_q != RAM_EMPTY) && (occ_s < (3'd2 + 3'(pop_s)));
        rd_word_s  = {RAM_RPARITY_B, RAM_RDATA_B};
`ifdef TDP36K_FIFO_PARITY_EN
        wparity_s  = byte_parity(stream.WR_DATA[31:0]);
`else
        wparity_s  = stream.WR_DATA[35:32];
`endif

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = 1'b0;
        buf_cnt_d  = buf_cnt_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        par_err_d  = par_err_q;

        if (FLUSH) begin
            wr_ptr_d  = PTR_ZERO;
            rd_ptr_d  = PTR_ZERO;
            ram_cnt_d = RAM_EMPTY;
            buf_cnt_d = 2'd0;
            buf0_d    = 36'h0;
            buf1_d    = 36'h0;
            par_err_d = 1'b0;
        end else begin
            wr_ptr_d   = push_s  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d   = issue_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            inflight_d = issue_s;
            case ({push_s, issue_s})
                2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
                2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
                default: ram_cnt_d = ram_cnt_q;
            endcase
            case ({pop_s, inflight_q})
                2'b10: begin
                    buf0_d    = buf1_q;
                    buf_cnt_d = buf_cnt_q - 2'd1;
                end
                2'b01: begin
                    if (buf_cnt_q == 2'd0) begin
                        buf0_d = rd_word_s;
                    end else begin
                        buf1_d = rd_word_s;
                    end
                    buf_cnt_d = buf_cnt_q + 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_q == 2'd1) begin
                        buf0_d = rd_word_s;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = rd_word_s;
                    end
                end
                default: begin
                    buf_cnt_d = buf_cnt_q;
                end
            endcase
`ifdef TDP36K_FIFO_PARITY_EN
            if (inflight_q && (byte_parity(RAM_RDATA_B) != RAM_RPARITY_B)) begin
                par_err_d = 1'b1;
            end else begin
                par_err_d = par_err_q;
            end
`else
            par_err_d = 1'b0;
`endif
        end

        count_d = (ADDR_WIDTH+2)'(ram_cnt_d) + (ADDR_WIDTH+2)'(inflight_d) + (ADDR_WIDTH+2)'(buf_cnt_d);
        af_d    = (count_d >= AF_THRESH);
    end

    // State registers; rdy_en_q holds WR_READY low until the first edge after reset release.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            ram_cnt_q  <= RAM_EMPTY;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= 36'h0;
            buf1_q     <= 36'h0;
            count_q    <= (ADDR_WIDTH+2)'(0);
            af_q       <= 1'b0;
            par_err_q  <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
            af_q       <= af_d;
            par_err_q  <= par_err_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign stream.WR_READY = wr_ready_s;
    assign stream.RD_DATA  = buf0_q;
    assign stream.RD_VALID = (buf_cnt_q != 2'd0);
    assign COUNT           = count_q;
    assign ALMOST_FULL     = af_q;
    assign PAR_ERR         = par_err_q;
    assign RAM_WEN_A       = push_s;
    assign RAM_BE_A        = push_s ? 4'hF : 4'h0;
    assign RAM_ADDR_A      = 15'(wr_ptr_q) << 4'd5;
    assign RAM_WDATA_A     = stream.WR_DATA[31:0];
    assign RAM_WPARITY_A   = wparity_s;
    assign RAM_REN_B       = issue_s;
    assign RAM_ADDR_B      = 15'(rd_ptr_q) << 4'd5;

endmodule

// File: tb/tb_tdp36k_fifo_ctrl.sv
// Directed bench for tdp36k_fifo_ctrl with a behavioural TDP_RAM36K model (1-cycle registered read).
module tb_tdp36k_fifo_ctrl;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [AW+1:0] count;
    logic          almost_full, par_err;
    logic          ram_wen_a, ram_ren_b;
    logic [3:0]    ram_be_a, ram_wparity_a, ram_rparity_b;
    logic [14:0]   ram_addr_a, ram_addr_b;
    logic [31:0]   ram_wdata_a, ram_rdata_b;
    logic [35:0]   mem [0:1023];
    logic [35:0]   ram_q;
    logic [3:0]    par_flip = 4'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int not_ready, cnt_err, af_err, data_err, bubbles, exp_v, pushed, popped;
    logic        fire_w, fire_r;
    logic [35:0] head;

    tdp36k_fifo_ctrl_if bus ();

    tdp36k_fifo_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_THRESH(1020)) dut (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .stream(bus),
        .COUNT(count), .ALMOST_FULL(almost_full), .PAR_ERR(par_err),
        .RAM_WEN_A(ram_wen_a), .RAM_BE_A(ram_be_a), .RAM_ADDR_A(ram_addr_a),
        .RAM_WDATA_A(ram_wdata_a), .RAM_WPARITY_A(ram_wparity_a),
        .RAM_REN_B(ram_ren_b), .RAM_ADDR_B(ram_addr_b),
        .RAM_RDATA_B(ram_rdata_b), .RAM_RPARITY_B(ram_rparity_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_wen_a) mem[ram_addr_a[14:5]] <= {ram_wparity_a, ram_wdata_a};
    always @(posedge clk) if (ram_ren_b) ram_q <= mem[ram_addr_b[14:5]];
    assign ram_rdata_b   = ram_q[31:0];
    assign ram_rparity_b = ram_q[35:32] ^ par_flip;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        bus.WR_DATA = 36'h0; bus.WR_VALID = 1'b0; bus.RD_READY = 1'b0;
        #12;
        check_eq("rst_wr_ready", bus.WR_READY, 1'b0);
        check_eq("rst_rd_valid", bus.RD_VALID, 1'b0);
        check_eq("rst_rd_data", bus.RD_DATA, 36'h0);
        check_eq("rst_count", count, 12'd0);
        check_eq("rst_af", almost_full, 1'b0);
        check_eq("rst_par_err", par_err, 1'b0);
        check_eq("rst_wen", ram_wen_a, 1'b0);
        check_eq("rst_ren", ram_ren_b, 1'b0);
        check_eq("rst_be", ram_be_a, 4'h0);
        #5 rst_n = 1'b1;
        #1;
        check_eq("rdy_before_edge", bus.WR_READY, 1'b0);
        tick();
        check_eq("rdy_after_edge", bus.WR_READY, 1'b1);

        // Single word latency from empty
        bus.WR_DATA = 36'h5_DEADBEEF; bus.WR_VALID = 1'b1;
        #1;
        check_eq("w1_wen", ram_wen_a, 1'b1);
        check_eq("w1_addr", ram_addr_a, 15'd0);
        check_eq("w1_be", ram_be_a, 4'hF);
        check_eq("w1_wdata", ram_wdata_a, 32'hDEADBEEF);
        check_eq("w1_wpar", ram_wparity_a, 4'h5);
        tick();
        bus.WR_VALID = 1'b0;
        check_eq("w1_count_n", count, 12'd1);
        check_eq("w1_valid_n", bus.RD_VALID, 1'b0);
        tick();
        check_eq("w1_valid_n1", bus.RD_VALID, 1'b0);
        tick();
        check_eq("w1_valid_n2", bus.RD_VALID, 1'b1);
        check_eq("w1_data", bus.RD_DATA, 36'h5_DEADBEEF);
        check_eq("w1_count_n2", count, 12'd1);
        bus.RD_READY = 1'b1;
        tick();
        bus.RD_READY = 1'b0;
        check_eq("w1_pop_valid", bus.RD_VALID, 1'b0);
        check_eq("w1_pop_count", count, 12'd0);

        // Fill to full with RD_READY low
        not_ready = 0; cnt_err = 0; af_err = 0;
        for (int i = 0; i < 1026; i++) begin
            bus.WR_DATA = 36'(i); bus.WR_VALID = 1'b1;
            #1;
            if (!bus.WR_READY) not_ready++;
            tick();
            if (count !== 12'(i + 1)) cnt_err++;
            if (almost_full !== ((i + 1) >= 1020)) af_err++;
        end
        check_eq("fill_not_ready", not_ready, 0);
        check_eq("fill_count_track", cnt_err, 0);
        check_eq("fill_af_track", af_err, 0);
        bus.WR_DATA = 36'd1026;
        #1;
        check_eq("full_wr_ready", bus.WR_READY, 1'b0);
        check_eq("full_wen", ram_wen_a, 1'b0);
        tick();
        check_eq("full_count", count, 12'd1026);
        check_eq("full_af", almost_full, 1'b1);
        bus.WR_VALID = 1'b0;

        // Drain at full rate
        exp_v = 0; bubbles = 0; data_err = 0;
        bus.RD_READY = 1'b1;
        for (int c = 0; c < 1100 && exp_v < 1026; c++) begin
            if (bus.RD_VALID) begin
                if (bus.RD_DATA !== 36'(exp_v)) data_err++;
                exp_v++;
            end else begin
                bubbles++;
            end
            tick();
        end
        bus.RD_READY = 1'b0;
        check_eq("drain_words", exp_v, 1026);
        check_eq("drain_data", data_err, 0);
        check_eq("drain_bubbles", bubbles, 0);
        check_eq("drain_count", count, 12'd0);
        check_eq("drain_valid", bus.RD_VALID, 1'b0);

        // Simultaneous push/pop streaming across pointer wrap
        pushed = 0; popped = 0; data_err = 0; cnt_err = 0;
        for (int c = 0; c < 6000 && popped < 5000; c++) begin
            bus.WR_VALID = (pushed < 5000);
            bus.WR_DATA  = 36'h1000_0000 + 36'(pushed);
            bus.RD_READY = 1'b1;
            #1;
            fire_w = bus.WR_VALID && bus.WR_READY;
            fire_r = bus.RD_VALID;
            head   = bus.RD_DATA;
            tick();
            if (fire_w) pushed++;
            if (fire_r) begin
                if (head !== 36'h1000_0000 + 36'(popped)) data_err++;
                popped++;
            end
            if (pushed > 10 && pushed < 4990 && count !== 12'd3) cnt_err++;
        end
        bus.WR_VALID = 1'b0; bus.RD_READY = 1'b0;
        check_eq("stream_pushed", pushed, 5000);
        check_eq("stream_popped", popped, 5000);
        check_eq("stream_data", data_err, 0);
        check_eq("stream_count_steady", cnt_err, 0);
        check_eq("stream_end_count", count, 12'd0);

        // FLUSH with COUNT=7 and a read in flight
        for (int i = 0; i < 7; i++) begin
            bus.WR_DATA = 36'h2_0000_0000 + 36'(i); bus.WR_VALID = 1'b1;
            tick();
        end
        check_eq("pre_flush_count7", count, 12'd7);
        bus.WR_DATA = 36'h2_0000_0007; bus.RD_READY = 1'b1;
        tick();
        bus.RD_READY = 1'b0;
        check_eq("pre_flush_count", count, 12'd7);
        bus.WR_DATA = 36'hB_ADBADBAD; flush = 1'b1;
        #1;
        check_eq("flush_wr_ready", bus.WR_READY, 1'b0);
        check_eq("flush_wen", ram_wen_a, 1'b0);
        tick();
        flush = 1'b0; bus.WR_VALID = 1'b0;
        check_eq("flush_count", count, 12'd0);
        check_eq("flush_valid", bus.RD_VALID, 1'b0);
        tick();
        tick();
        check_eq("flush_dropped_valid", bus.RD_VALID, 1'b0);
        check_eq("flush_dropped_count", count, 12'd0);
        bus.WR_DATA = 36'h9_12345678; bus.WR_VALID = 1'b1;
        tick();
        bus.WR_VALID = 1'b0;
        tick();
        tick();
        check_eq("post_flush_valid", bus.RD_VALID, 1'b1);
        check_eq("post_flush_data", bus.RD_DATA, 36'h9_12345678);
        bus.RD_READY = 1'b1;
        tick();

        // Asynchronous reset mid-burst
        bus.WR_VALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.WR_DATA = 36'h3_0000_0000 + 36'(i);
            tick();
        end
        check_eq("pre_rst_valid", bus.RD_VALID, 1'b1);
        check_eq("pre_rst_wen", ram_wen_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", bus.RD_VALID, 1'b0);
        check_eq("mid_rst_wr_ready", bus.WR_READY, 1'b0);
        check_eq("mid_rst_wen", ram_wen_a, 1'b0);
        check_eq("mid_rst_ren", ram_ren_b, 1'b0);
        check_eq("mid_rst_count", count, 12'd0);
        bus.WR_VALID = 1'b0; bus.RD_READY = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_wr_ready", bus.WR_READY, 1'b1);
        check_eq("post_rst_valid", bus.RD_VALID, 1'b0);
        check_eq("post_rst_count", count, 12'd0);

`ifdef TDP36K_FIFO_PARITY_EN
        bus.WR_DATA = 36'h0_0000_00FF; bus.WR_VALID = 1'b1;
        #1;
        check_eq("par_wparity_ff", ram_wparity_a, 4'h0);
        par_flip = 4'b0001;
        tick();
        bus.WR_VALID = 1'b0;
        tick();
        tick();
        check_eq("par_valid", bus.RD_VALID, 1'b1);
        check_eq("par_rd_data", bus.RD_DATA, 36'h1_0000_00FF);
        check_eq("par_err_set", par_err, 1'b1);
        tick();
        tick();
        check_eq("par_err_sticky", par_err, 1'b1);
        par_flip = 4'h0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("par_err_flushed", par_err, 1'b0);
        bus.WR_DATA = 36'hF_0000_0001; bus.WR_VALID = 1'b1;
        #1;
        check_eq("par_wparity_01", ram_wparity_a, 4'h1);
        tick();
        bus.WR_VALID = 1'b0;
        tick();
        tick();
        check_eq("par_clean_data", bus.RD_DATA, 36'h1_0000_0001);
        check_eq("par_clean_err", par_err, 1'b0);
`else
        check_eq("par_err_tied", par_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
